// File: rtl/upsample_scheduler.sv
// upsample_scheduler: control sequencer for a single-MAC polyphase zero-stuffing interpolator
module upsample_scheduler #(
    parameter int STUFFING       = 4,
    parameter int TAPS_PER_PHASE = 12,
    parameter int MAC_LATENCY    = 2,
    localparam int L  = STUFFING + 1,
    localparam int AW = (TAPS_PER_PHASE > 1) ? $clog2(TAPS_PER_PHASE) : 1,
    localparam int CW = (TAPS_PER_PHASE * L > 1) ? $clog2(TAPS_PER_PHASE * L) : 1,
    localparam int PW = (L > 1) ? $clog2(L) : 1,
    localparam int KM = (TAPS_PER_PHASE > MAC_LATENCY) ? TAPS_PER_PHASE : MAC_LATENCY,
    localparam int KW = $clog2(KM + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic          out_tick,
    input  logic          clr_flags,
    output logic          smp_we,
    output logic          smp_zero,
    output logic [AW-1:0] smp_waddr,
    output logic [AW-1:0] smp_raddr,
    output logic [CW-1:0] coef_addr,
    output logic          mac_en,
    output logic          mac_clr,
    output logic          acc_valid,
    output logic [PW-1:0] phase,
    output logic          busy,
    output logic          underrun,
    output logic          overrun
);
    typedef enum logic [2:0] {INIT, IDLE, MAC, DRAIN, DONE} state_t;

    state_t        state, state_n;
    logic [KW-1:0] k, k_n;
    logic [AW-1:0] wptr, wptr_n, wnext, ka;
    logic [PW-1:0] phase_n;
    logic          have_new, have_new_n;
    logic          we, zero, xfer, under_set, over_set;

    assign ka       = AW'(k);
    assign wnext    = (wptr == AW'(TAPS_PER_PHASE - 1)) ? '0 : wptr + AW'(1);
    assign in_ready = (state == IDLE) && !have_new;
    assign xfer     = in_valid && in_ready;
    assign busy     = state != IDLE;
    assign over_set = out_tick && busy;
    // the INIT sweep write strobe must stay quiet while reset is held
    assign smp_we   = we && reset;
    assign smp_zero = zero && reset;

    // next-state and datapath control for the buffer clear, input writes and the dot-product sweep
    always_comb begin
        state_n    = state;
        k_n        = k;
        wptr_n     = wptr;
        have_new_n = have_new;
        phase_n    = phase;
        we         = 1'b0;
        zero       = 1'b0;
        smp_waddr  = '0;
        smp_raddr  = '0;
        coef_addr  = '0;
        mac_en     = 1'b0;
        mac_clr    = 1'b0;
        acc_valid  = 1'b0;
        under_set  = 1'b0;
        case (state)
            INIT: begin
                we        = 1'b1;
                zero      = 1'b1;
                smp_waddr = ka;
                k_n       = k + KW'(1);
                if (k == KW'(TAPS_PER_PHASE - 1)) begin
                    state_n = IDLE;
                    k_n     = '0;
                end
            end
            IDLE: begin
                if (xfer) begin
                    we         = 1'b1;
                    smp_waddr  = wnext;
                    wptr_n     = wnext;
                    have_new_n = 1'b1;
                end
                if (out_tick) begin
                    state_n = MAC;
                    if (phase == '0) begin
                        if (xfer || have_new) begin
                            have_new_n = 1'b0;
                        end else begin
                            we        = 1'b1;
                            zero      = 1'b1;
                            smp_waddr = wnext;
                            wptr_n    = wnext;
                            under_set = 1'b1;
                        end
                    end
                end
            end
            MAC: begin
                mac_en    = 1'b1;
                mac_clr   = k == '0;
                smp_raddr = (wptr >= ka) ? wptr - ka : wptr + AW'(TAPS_PER_PHASE) - ka;
                coef_addr = CW'(ka) * CW'(L) + CW'(phase);
                k_n       = k + KW'(1);
                if (k == KW'(TAPS_PER_PHASE - 1)) begin
                    state_n = DRAIN;
                    k_n     = '0;
                end
            end
            DRAIN: begin
                k_n = k + KW'(1);
                if (k == KW'(MAC_LATENCY - 1)) begin
                    state_n = DONE;
                    k_n     = '0;
                end
            end
            DONE: begin
                acc_valid = 1'b1;
                phase_n   = (phase == PW'(L - 1)) ? '0 : phase + PW'(1);
                state_n   = IDLE;
            end
            default: state_n = INIT;
        endcase
    end

    // sequencer state, term counter, buffer write pointer and output phase
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= INIT;
            k        <= '0;
            wptr     <= AW'(TAPS_PER_PHASE - 1);
            have_new <= 1'b0;
            phase    <= '0;
        end else begin
            state    <= state_n;
            k        <= k_n;
            wptr     <= wptr_n;
            have_new <= have_new_n;
            phase    <= phase_n;
        end
    end

    // sticky error flags; a new event wins over a clear in the same cycle
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            underrun <= 1'b0;
            overrun  <= 1'b0;
        end else begin
            underrun <= under_set || (underrun && !clr_flags);
            overrun  <= over_set || (overrun && !clr_flags);
        end
    end
endmodule

// File: tb/tb_upsample_scheduler.sv
// tb_upsample_scheduler: scenario tasks plus a sample-history reference model for upsample_scheduler
module tb_upsample_scheduler;
    localparam int N = 12;
    localparam int L = 5;

    logic       clk = 1'b0, reset = 1'b0, in_valid = 1'b0, out_tick = 1'b0, clr_flags = 1'b0;
    logic       in_ready, smp_we, smp_zero, mac_en, mac_clr, acc_valid, busy, underrun, overrun;
    logic [3:0] smp_waddr, smp_raddr;
    logic [5:0] coef_addr;
    logic [2:0] phase;

    int din, cycle, idle_at, mph, n_vec, n_err, acc;
    bit pend, m_under, m_over;
    int hist[$], exp_val[$], exp_at[$];
    int coef[64];
    int ram[16];

    always #5 clk = ~clk;

    upsample_scheduler dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .out_tick(out_tick), .clr_flags(clr_flags), .smp_we(smp_we), .smp_zero(smp_zero),
        .smp_waddr(smp_waddr), .smp_raddr(smp_raddr), .coef_addr(coef_addr),
        .mac_en(mac_en), .mac_clr(mac_clr), .acc_valid(acc_valid), .phase(phase),
        .busy(busy), .underrun(underrun), .overrun(overrun)
    );

    // external sample RAM, coefficient ROM and MAC driven by the scheduler's addresses
    always @(posedge clk) begin
        if (smp_we) ram[smp_waddr] <= smp_zero ? 0 : din;
        if (mac_en) acc <= (mac_clr ? 0 : acc) + ram[smp_raddr] * coef[coef_addr];
    end

    // expected output: newest N samples of the input history against one coefficient phase
    function automatic int dot(int ph);
        int s = 0;
        for (int j = 0; j < N; j++) s += hist[hist.size() - 1 - j] * coef[j * L + ph];
        return s;
    endfunction

    task automatic model_reset;
        hist.delete();
        for (int j = 0; j < N; j++) hist.push_back(0);
        pend = 0; mph = 0; m_under = 0; m_over = 0;
        exp_val.delete(); exp_at.delete();
        idle_at = 1 << 30;
    endtask

    task automatic cyc;
        bit idle, rdy, wr, wz, av;
        #1;
        idle = reset && cycle >= idle_at;
        rdy = idle && !pend;
        wr = rdy && in_valid;
        wz = 0;
        if (idle && out_tick && mph == 0 && !pend && !wr) begin wr = 1; wz = 1; end
        if (reset) begin
            n_vec++;
            if (in_ready !== rdy) begin n_err++; $display("FAIL in_ready @%0d: got %b want %b", cycle, in_ready, rdy); end
            if (idle) begin
                n_vec++;
                if (smp_we !== wr) begin n_err++; $display("FAIL smp_we @%0d: got %b want %b", cycle, smp_we, wr); end
                if (wr) begin
                    n_vec++;
                    if (smp_zero !== wz || smp_waddr !== 4'(hist.size() % N)) begin
                        n_err++;
                        $display("FAIL write @%0d: got zero=%b addr=%0d want zero=%b addr=%0d", cycle, smp_zero, smp_waddr, wz, hist.size() % N);
                    end
                end
            end
            if (rdy && in_valid) begin hist.push_back(din); pend = 1; end
            if (clr_flags) begin m_under = 0; m_over = 0; end
            if (out_tick) begin
                if (idle) begin
                    if (mph == 0) begin
                        if (pend) pend = 0;
                        else begin hist.push_back(0); m_under = 1; end
                    end
                    exp_val.push_back(dot(mph));
                    exp_at.push_back(cycle + 15);
                    mph = (mph + 1) % L;
                    idle_at = cycle + 16;
                end else m_over = 1;
            end
        end
        @(posedge clk);
        #1;
        cycle++;
        if (reset) begin
            idle = cycle >= idle_at;
            av = exp_at.size() > 0 && exp_at[0] == cycle;
            n_vec += 4;
            if (busy !== !idle) begin n_err++; $display("FAIL busy @%0d: got %b want %b", cycle, busy, !idle); end
            if (acc_valid !== av) begin n_err++; $display("FAIL acc_valid @%0d: got %b want %b", cycle, acc_valid, av); end
            if (underrun !== m_under) begin n_err++; $display("FAIL underrun @%0d: got %b want %b", cycle, underrun, m_under); end
            if (overrun !== m_over) begin n_err++; $display("FAIL overrun @%0d: got %b want %b", cycle, overrun, m_over); end
            if (av) begin
                n_vec++;
                if (acc !== exp_val[0]) begin n_err++; $display("FAIL dot_product @%0d: got %0d want %0d", cycle, acc, exp_val[0]); end
                exp_at.pop_front();
                exp_val.pop_front();
            end
            if (idle) begin
                n_vec++;
                if (phase !== 3'(mph)) begin n_err++; $display("FAIL phase @%0d: got %0d want %0d", cycle, phase, mph); end
            end
        end
    endtask

    task automatic tick_run;
        out_tick = 1; cyc; out_tick = 0;
        repeat (15) cyc;
    endtask

    task automatic test_reset;
        model_reset;
        reset = 0;
        cyc; cyc;
        n_vec += 2;
        if ({busy, in_ready, smp_we, smp_zero, mac_en, mac_clr, acc_valid, underrun, overrun} !== 9'b100000000) begin
            n_err++; $display("FAIL reset_ctrl: got %b want 100000000", {busy, in_ready, smp_we, smp_zero, mac_en, mac_clr, acc_valid, underrun, overrun});
        end
        if ({smp_waddr, smp_raddr, coef_addr, phase} !== 17'd0) begin
            n_err++; $display("FAIL reset_addr: got %h want 0", {smp_waddr, smp_raddr, coef_addr, phase});
        end
        reset = 1;
        idle_at = cycle + N;
        #1;
        for (int i = 0; i < N; i++) begin
            n_vec++;
            if (smp_we !== 1 || smp_zero !== 1 || smp_waddr !== 4'(i) || busy !== 1) begin
                n_err++; $display("FAIL init_sweep %0d: got we=%b zero=%b addr=%0d busy=%b want 1 1 %0d 1", i, smp_we, smp_zero, smp_waddr, busy, i);
            end
            cyc;
        end
        n_vec++;
        if (in_ready !== 1 || busy !== 0 || underrun !== 0 || overrun !== 0) begin
            n_err++; $display("FAIL post_init: got rdy=%b busy=%b un=%b ov=%b want 1 0 0 0", in_ready, busy, underrun, overrun);
        end
    endtask

    task automatic test_single;
        in_valid = 1; din = int'($urandom_range(1, 1000));
        #1;
        n_vec++;
        if (smp_we !== 1 || smp_zero !== 0 || smp_waddr !== 0) begin
            n_err++; $display("FAIL first_write: got we=%b zero=%b addr=%0d want 1 0 0", smp_we, smp_zero, smp_waddr);
        end
        cyc;
        in_valid = 0;
        out_tick = 1; cyc; out_tick = 0;
        for (int i = 0; i < N; i++) begin
            n_vec++;
            if (mac_en !== 1 || mac_clr !== (i == 0) || smp_raddr !== 4'((N - i) % N) || coef_addr !== 6'(i * L)) begin
                n_err++; $display("FAIL mac_term %0d: got en=%b clr=%b raddr=%0d caddr=%0d want 1 %b %0d %0d", i, mac_en, mac_clr, smp_raddr, coef_addr, i == 0, (N - i) % N, i * L);
            end
            cyc;
        end
        repeat (3) cyc;
        n_vec++;
        if (phase !== 3'd1) begin n_err++; $display("FAIL phase_after_first: got %0d want 1", phase); end
    endtask

    task automatic test_phases;
        for (int p = 1; p < L; p++) begin
            out_tick = 1; cyc; out_tick = 0;
            for (int i = 0; i < N; i++) begin
                if (p == 2) begin
                    n_vec++;
                    if (coef_addr !== 6'(i * L + 2)) begin n_err++; $display("FAIL phase2_coef %0d: got %0d want %0d", i, coef_addr, i * L + 2); end
                end
                cyc;
            end
            repeat (3) cyc;
        end
        n_vec++;
        if (phase !== 3'd0) begin n_err++; $display("FAIL phase_wrap: got %0d want 0", phase); end
        in_valid = 1; din = int'($urandom_range(1, 1000)); cyc; in_valid = 0;
        repeat (4) begin
            n_vec++;
            if (in_ready !== 0) begin n_err++; $display("FAIL ready_while_pending: got %b want 0", in_ready); end
            cyc;
        end
        tick_run;
        n_vec++;
        if (in_ready !== 1) begin n_err++; $display("FAIL ready_after_consume: got %b want 1", in_ready); end
    endtask

    task automatic test_underrun;
        repeat (L - 1) tick_run;
        n_vec++;
        if (phase !== 3'd0) begin n_err++; $display("FAIL underrun_phase: got %0d want 0", phase); end
        out_tick = 1;
        #1;
        n_vec++;
        if (smp_we !== 1 || smp_zero !== 1 || smp_waddr !== 4'(hist.size() % N)) begin
            n_err++; $display("FAIL zero_stuff: got we=%b zero=%b addr=%0d want 1 1 %0d", smp_we, smp_zero, smp_waddr, hist.size() % N);
        end
        cyc; out_tick = 0;
        n_vec++;
        if (underrun !== 1) begin n_err++; $display("FAIL underrun_set: got %b want 1", underrun); end
        repeat (15) cyc;
        clr_flags = 1; cyc; clr_flags = 0;
        n_vec++;
        if (underrun !== 0) begin n_err++; $display("FAIL underrun_clear: got %b want 0", underrun); end
    endtask

    task automatic test_overrun;
        int p0, cnt;
        p0 = mph; cnt = 0;
        out_tick = 1; cyc; out_tick = 0;
        repeat (4) cyc;
        out_tick = 1; cyc; out_tick = 0;
        n_vec++;
        if (overrun !== 1) begin n_err++; $display("FAIL overrun_set: got %b want 1", overrun); end
        repeat (20) begin cyc; cnt += int'(acc_valid); end
        n_vec += 2;
        if (cnt != 1) begin n_err++; $display("FAIL overrun_single_result: got %0d want 1", cnt); end
        if (phase !== 3'((p0 + 1) % L)) begin n_err++; $display("FAIL overrun_phase: got %0d want %0d", phase, (p0 + 1) % L); end
        clr_flags = 1; cyc; clr_flags = 0;
    endtask

    task automatic test_reset_mid;
        out_tick = 1; cyc; out_tick = 0;
        repeat (6) cyc;
        n_vec++;
        if (mac_en !== 1 || coef_addr !== 6'(6 * L + mph - 1)) begin
            n_err++; $display("FAIL mid_mac: got en=%b caddr=%0d want 1 %0d", mac_en, coef_addr, 6 * L + mph - 1);
        end
        reset = 0;
        #1;
        n_vec += 2;
        if ({busy, in_ready, smp_we, smp_zero, mac_en, mac_clr, acc_valid, underrun, overrun} !== 9'b100000000) begin
            n_err++; $display("FAIL midreset_ctrl: got %b want 100000000", {busy, in_ready, smp_we, smp_zero, mac_en, mac_clr, acc_valid, underrun, overrun});
        end
        if ({smp_waddr, smp_raddr, coef_addr, phase} !== 17'd0) begin
            n_err++; $display("FAIL midreset_addr: got %h want 0", {smp_waddr, smp_raddr, coef_addr, phase});
        end
        model_reset;
        cyc; cyc;
        reset = 1;
        idle_at = cycle + N;
        #1;
        for (int i = 0; i < N; i++) begin
            n_vec++;
            if (smp_we !== 1 || smp_zero !== 1 || smp_waddr !== 4'(i)) begin
                n_err++; $display("FAIL reinit_sweep %0d: got we=%b zero=%b addr=%0d want 1 1 %0d", i, smp_we, smp_zero, smp_waddr, i);
            end
            cyc;
        end
        for (int s = 0; s < 13; s++) begin
            in_valid = 1; din = int'($urandom_range(1, 1000));
            if (s == 12) begin
                #1;
                n_vec++;
                if (smp_we !== 1 || smp_zero !== 0 || smp_waddr !== 0) begin
                    n_err++; $display("FAIL wrap_write: got we=%b zero=%b addr=%0d want 1 0 0", smp_we, smp_zero, smp_waddr);
                end
            end
            cyc;
            in_valid = 0;
            repeat (L) tick_run;
        end
    endtask

    task automatic test_random;
        repeat (3000) begin
            in_valid = $urandom_range(0, 3) == 0;
            din = int'($urandom_range(1, 1000));
            out_tick = $urandom_range(0, 14) == 0;
            clr_flags = $urandom_range(0, 39) == 0;
            cyc;
        end
        in_valid = 0; out_tick = 0; clr_flags = 0;
        repeat (20) cyc;
    endtask

    initial begin
        for (int i = 0; i < 64; i++) coef[i] = (i < N * L) ? int'($urandom_range(1, 1000)) : 0;
        for (int i = 0; i < 16; i++) ram[i] = 0;
        acc = 0; cycle = 0; n_vec = 0; n_err = 0; din = 0;
        test_reset;
        test_single;
        test_phases;
        test_underrun;
        test_overrun;
        test_reset_mid;
        test_random;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
